ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- Execute→Memory pipeline stage directly downstream of the execute conditional unit.
- Registers the condition-qualified control bits (BranchTaken, PCSrc, RegWrite, MemWrite) together with scalar and vector execute results.
- Serializes 128-bit vector stores into SW-wide memory write beats.
- While a burst is in progress, holds the upstream pipeline through BusyM.

Parameters:
- SW, 32, scalar datapath and memory data width
- VW, 128, vector register width; must be an integer multiple of SW
- RW, 5, register address width
- NBEATS, VW/SW (derived, localparam), write beats per vector store

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- StallM  in  1  hold stage contents (from hazard unit)
- FlushM  in  1  insert bubble (from hazard unit)
- BranchTakenE  in  1  qualified branch-taken from conditional unit
- PCSrcECU  in  1  qualified PC-source write
- RegWriteECU  in  1  qualified register write
- MemWriteECU  in  1  qualified memory write
- MemtoRegE  in  1  writeback selects memory data
- VecSelE  in  1  1 = vector instruction
- ALUResultE  in  SW  scalar result / effective address
- ALUResultVE  in  VW  vector result
- WriteDataVE  in  VW  vector store data (scalar store uses bits [SW-1:0])
- WA3E  in  RW  destination register
- BranchTakenM, PCSrcM, RegWriteM, MemtoRegM, VecSelM  out  1  registered controls
- ALUResultM  out  SW  registered scalar result
- ALUResultVM  out  VW  registered vector result
- WA3M  out  RW  registered destination
- ValidM  out  1  stage holds a real instruction
- MemWriteOutM  out  1  memory write strobe for the current beat
- MemAddrM  out  SW  memory byte address for the current beat
- MemDataM  out  SW  memory write data for the current beat
- BusyM  out  1  serializer needs more cycles; hazard unit stalls F/D/E

Behaviour:
- Update priority on each clk edge: reset > (Busy hold) > FlushM > StallM > capture.
- Reset (rst=0): all outputs 0, ValidM=0, FSM=IDLE, beat counter=0, pending-flush=0.
- Capture: all *E inputs load into *M regs. ValidM=1. Beat counter=0.
- Latency: one cycle from E to M for every field.
- FlushM (not busy): control bits, ValidM, and all data registers load 0 (bubble).
- StallM (not busy): all registers hold. MemWriteOutM is still driven from held state, so a held scalar store re-asserts its strobe. The hazard unit guarantees StallM is never asserted with a store in M.
- Scalar store (MemWriteM & !VecSelM), combinational outputs:
  - MemWriteOutM=1, MemAddrM=ALUResultM, MemDataM=WriteDataVM[SW-1:0].
  - BusyM=0; occupies M for one cycle.
- Vector store (MemWriteM & VecSelM): FSM IDLE→BURST on capture. In beat k (0..NBEATS-1):
  - MemWriteOutM=1.
  - MemAddrM=ALUResultM + k*(SW/8), wrap-around modulo 2^SW.
  - MemDataM=WriteDataVM[k*SW +: SW].
  - BusyM=1 for k<NBEATS-1, and 0 in the last beat, so the next instruction captures on the edge ending that beat. FSM returns to IDLE.
- While BusyM=1:
  - Registers hold and the counter increments.
  - StallM is ignored.
  - FlushM is latched into pending-flush and is not applied, because a qualified store in M is committed and never aborted.
  - At the burst-completing edge, pending-flush=1 loads a bubble instead of capturing, then clears.
  - FlushM asserted in the last beat (BusyM=0) acts normally.
- Non-store instructions: MemWriteOutM=0, MemAddrM=ALUResultM, MemDataM=0.
- A vector store with MemWriteECU=0 (condition failed) is a bubble-like no-op: ValidM=1, no beats.
- Reset mid-burst: abort immediately; all outputs 0 on the next cycle.
- BranchTakenM/PCSrcM are pure registered copies; they are not affected by the burst.

Decomposition:
- Shared package proc_pkg: SW, VW, RW constants; typedef mem_state_t {IDLE, BURST}; typedef for the E→M control bundle (struct of the 1-bit controls plus WA3).
- Sub-module vector_store_serializer:
  - Contains the FSM, beat counter, and pending-flush bit.
  - Drives MemWriteOutM/MemAddrM/MemDataM/BusyM.
- The top level holds the pipeline registers.

Test Plan:
- Reset mid-operation: rst=0 during beat 1 of a vector store → next cycle all outputs 0, BusyM=0, FSM=IDLE.
- Scalar store: MemWriteECU=1, VecSelE=0, ALUResultE=0x100, WriteDataVE[31:0]=0xDEADBEEF → one cycle later MemWriteOutM=1, MemAddrM=0x100, MemDataM=0xDEADBEEF, BusyM=0.
- Vector store: ALUResultE=0x200, WriteDataVE=0x44444444_33333333_22222222_11111111 → 4 beats:
  - Addresses 0x200/0x204/0x208/0x20C.
  - Data 0x11111111/0x22222222/0x33333333/0x44444444.
  - BusyM=1,1,1,0.
  - Next instruction captured after beat 3.
- Address wrap: vector store at 0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Flush mid-burst: FlushM=1 during beat 1 → burst completes all 4 beats; the cycle after the last beat shows ValidM=0, RegWriteM=0.
- Stall/flush on a non-store: StallM=1 holds RegWriteM=1, WA3M=7 for 3 cycles; FlushM=1 (StallM=0) then gives ValidM=0, RegWriteM=0, PCSrcM=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants and types for the execute/memory pipeline boundary.
package proc_pkg;
    localparam int SW = 32;
    localparam int VW = 128;
    localparam int RW = 5;

    typedef enum logic {IDLE, BURST} mem_state_t;

    // Condition-qualified control bundle carried from E to M.
    typedef struct packed {
        logic          branchTaken;
        logic          pcSrc;
        logic          regWrite;
        logic          memWrite;
        logic          memtoReg;
        logic          vecSel;
        logic [RW-1:0] wa3;
    } exm_ctrl_t;
endpackage

// File: rtl/vector_store_serializer.sv
// Splits a vector store held in M into SW-wide memory write beats and
// drives the per-beat strobe, address and data plus the upstream hold.
module vector_store_serializer #(
    parameter int SW = proc_pkg::SW,
    parameter int VW = proc_pkg::VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          startBurst,
    input  logic          flush,
    input  logic          memWrite,
    input  logic          vecSel,
    input  logic [SW-1:0] addrBase,
    input  logic [VW-1:0] storeData,
    output logic          busy,
    output logic          flushPending,
    output logic          memWriteOut,
    output logic [SW-1:0] memAddr,
    output logic [SW-1:0] memData
);
    import proc_pkg::*;

    localparam int NBEATS  = VW / SW;
    localparam int CW      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int BYTE_SH = $clog2(SW / 8);

    mem_state_t state, stateNext;
    logic [CW-1:0] beat, beatNext;
    logic pend, pendNext;
    logic lastBeat;
    logic [NBEATS-1:0][SW-1:0] beats;

    assign beats        = storeData;
    assign lastBeat     = (beat == CW'(NBEATS - 1));
    assign busy         = (state == BURST) && !lastBeat;
    assign flushPending = pend;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            beat  <= '0;
            pend  <= 1'b0;
        end else begin
            state <= stateNext;
            beat  <= beatNext;
            pend  <= pendNext;
        end
    end

    // A flush seen mid-burst is remembered; it is consumed on the edge that
    // ends the burst, where the stage loads a bubble instead of capturing.
    always_comb begin
        stateNext = IDLE;
        beatNext  = '0;
        pendNext  = 1'b0;
        case (state)
            IDLE: begin
                if (load && startBurst) stateNext = BURST;
            end
            BURST: begin
                if (!lastBeat) begin
                    stateNext = BURST;
                    beatNext  = beat + 1'b1;
                    pendNext  = pend | flush;
                end else if (load && startBurst) begin
                    stateNext = BURST;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        memWriteOut = 1'b0;
        memAddr     = addrBase;
        memData     = '0;
        if (state == BURST) begin
            memWriteOut = 1'b1;
            memAddr     = addrBase + (SW'(beat) << BYTE_SH);
            memData     = beats[beat];
        end else if (memWrite && !vecSel) begin
            memWriteOut = 1'b1;
            memData     = beats[0];
        end
    end
endmodule

// File: rtl/ex_mem_stage.sv
// Execute->Memory pipeline register with vector-store serialization;
// holds the upstream pipeline through BusyM while a burst is in flight.
module ex_mem_stage #(
    parameter int SW = proc_pkg::SW,
    parameter int VW = proc_pkg::VW,
    parameter int RW = proc_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          StallM,
    input  logic          FlushM,
    input  logic          BranchTakenE,
    input  logic          PCSrcECU,
    input  logic          RegWriteECU,
    input  logic          MemWriteECU,
    input  logic          MemtoRegE,
    input  logic          VecSelE,
    input  logic [SW-1:0] ALUResultE,
    input  logic [VW-1:0] ALUResultVE,
    input  logic [VW-1:0] WriteDataVE,
    input  logic [RW-1:0] WA3E,
    output logic          BranchTakenM,
    output logic          PCSrcM,
    output logic          RegWriteM,
    output logic          MemtoRegM,
    output logic          VecSelM,
    output logic [SW-1:0] ALUResultM,
    output logic [VW-1:0] ALUResultVM,
    output logic [RW-1:0] WA3M,
    output logic          ValidM,
    output logic          MemWriteOutM,
    output logic [SW-1:0] MemAddrM,
    output logic [SW-1:0] MemDataM,
    output logic          BusyM
);
    import proc_pkg::*;

    exm_ctrl_t ctrlE, ctrlM;
    logic [VW-1:0] WriteDataVM;
    logic flushPending;
    logic load;

    assign ctrlE = '{branchTaken: BranchTakenE, pcSrc: PCSrcECU,
                     regWrite: RegWriteECU, memWrite: MemWriteECU,
                     memtoReg: MemtoRegE, vecSel: VecSelE, wa3: WA3E};

    assign load = !BusyM && !flushPending && !FlushM && !StallM;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrlM       <= '0;
            ValidM      <= 1'b0;
            ALUResultM  <= '0;
            ALUResultVM <= '0;
            WriteDataVM <= '0;
        end else if (!BusyM) begin
            if (flushPending || FlushM) begin
                ctrlM       <= '0;
                ValidM      <= 1'b0;
                ALUResultM  <= '0;
                ALUResultVM <= '0;
                WriteDataVM <= '0;
            end else if (!StallM) begin
                ctrlM       <= ctrlE;
                ValidM      <= 1'b1;
                ALUResultM  <= ALUResultE;
                ALUResultVM <= ALUResultVE;
                WriteDataVM <= WriteDataVE;
            end
        end
    end

    assign BranchTakenM = ctrlM.branchTaken;
    assign PCSrcM       = ctrlM.pcSrc;
    assign RegWriteM    = ctrlM.regWrite;
    assign MemtoRegM    = ctrlM.memtoReg;
    assign VecSelM      = ctrlM.vecSel;
    assign WA3M         = ctrlM.wa3;

    vector_store_serializer #(.SW(SW), .VW(VW)) uSer (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .startBurst  (MemWriteECU && VecSelE),
        .flush       (FlushM),
        .memWrite    (ctrlM.memWrite),
        .vecSel      (ctrlM.vecSel),
        .addrBase    (ALUResultM),
        .storeData   (WriteDataVM),
        .busy        (BusyM),
        .flushPending(flushPending),
        .memWriteOut (MemWriteOutM),
        .memAddr     (MemAddrM),
        .memData     (MemDataM)
    );
endmodule
